// File: rtl/path_gen_multi.sv
// ============================================================================
//  Module   : path_gen_multi
//  Purpose  : Monte-Carlo price-path generator. One start produces NUM_PATHS
//             paths of NUM_DAYS days each, with S_d = (q +/- w*|eps|) * S_(d-1)
//             and S_(-1) = S0. Normal samples arrive on a valid/ready stream;
//             each day value leaves tagged with its day and path index.
//             FP12 is unsigned 12-bit fixed point with 8 fractional bits;
//             FP12_MULT(a,b) keeps bits [19:8] of the 24-bit product.
//  Ports    :
//    clk           in   clock
//    rst_n         in   asynchronous active-low reset
//    i_start       in   begin a run (sampled only when idle)
//    i_w           in   FP12 volatility term, latched on accepted start
//    i_q           in   FP12 drift term, latched on accepted start
//    i_s0          in   FP12 initial price, latched on accepted start
//    i_abort       in   synchronous flush, any state
//    i_eps_valid   in   epsilon sample valid
//    i_epsilon     in   [12] sign, [11:0] FP12 magnitude
//    o_eps_ready   out  high only while running
//    o_busy        out  high whenever not idle
//    o_path_valid  out  one-cycle strobe per produced day
//    o_path        out  FP12 price S_d
//    o_path_day    out  day index d
//    o_path_idx    out  path index p
//    o_path_last   out  last day of last path
//    o_done        out  one-cycle completion pulse
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module path_gen_multi #(
   parameter int NUM_DAYS  = 8,
   parameter int NUM_PATHS = 4,
   parameter int DAY_W     = 3,
   parameter int PATH_W    = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_start,
   input  logic [11:0]       i_w,
   input  logic [11:0]       i_q,
   input  logic [11:0]       i_s0,
   input  logic              i_abort,
   input  logic              i_eps_valid,
   input  logic [12:0]       i_epsilon,
   output logic              o_eps_ready,
   output logic              o_busy,
   output logic              o_path_valid,
   output logic [11:0]       o_path,
   output logic [DAY_W-1:0]  o_path_day,
   output logic [PATH_W-1:0] o_path_idx,
   output logic              o_path_last,
   output logic              o_done
);

   localparam logic [DAY_W-1:0]  c_LAST_DAY  = DAY_W'(NUM_DAYS - 1);
   localparam logic [PATH_W-1:0] c_LAST_PATH = PATH_W'(NUM_PATHS - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_DRAIN = 2'd2
   } state_t;

   function automatic logic [11:0] fp12_mult(input logic [11:0] a, input logic [11:0] b);
      return 12'((24'(a) * 24'(b)) >> 8);
   endfunction

   state_t              r_state;
   logic [11:0]         r_w, r_q, r_s0;
   logic [DAY_W-1:0]    r_day_cnt;
   logic [PATH_W-1:0]   r_path_cnt;
   logic                r_eps_ready, r_busy, r_done;
   // S1
   logic                r_v1, r_sign1;
   logic [11:0]         r_prod;
   logic [DAY_W-1:0]    r_day1;
   logic [PATH_W-1:0]   r_path1;
   // S2
   logic                r_v2;
   logic [11:0]         r_sum;
   logic [DAY_W-1:0]    r_day2;
   logic [PATH_W-1:0]   r_path2;
   // S3 / outputs
   logic                r_path_valid, r_path_last;
   logic [11:0]         r_path;
   logic [DAY_W-1:0]    r_path_day;
   logic [PATH_W-1:0]   r_path_idx;

   logic w_accept, w_last_accept;

   assign w_accept      = i_eps_valid & r_eps_ready;
   assign w_last_accept = w_accept && (r_day_cnt == c_LAST_DAY) && (r_path_cnt == c_LAST_PATH);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= S_IDLE;
         r_w          <= '0;
         r_q          <= '0;
         r_s0         <= '0;
         r_day_cnt    <= '0;
         r_path_cnt   <= '0;
         r_eps_ready  <= 1'b0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_v1         <= 1'b0;
         r_sign1      <= 1'b0;
         r_prod       <= '0;
         r_day1       <= '0;
         r_path1      <= '0;
         r_v2         <= 1'b0;
         r_sum        <= '0;
         r_day2       <= '0;
         r_path2      <= '0;
         r_path_valid <= 1'b0;
         r_path_last  <= 1'b0;
         r_path       <= '0;
         r_path_day   <= '0;
         r_path_idx   <= '0;
      end else begin
         r_done <= 1'b0;

         // Datapath registers move every cycle; only the valids qualify them.
         r_v1    <= w_accept;
         r_sign1 <= i_epsilon[12];
         r_prod  <= fp12_mult(r_w, i_epsilon[11:0]);
         r_day1  <= r_day_cnt;
         r_path1 <= r_path_cnt;

         r_v2    <= r_v1;
         r_sum   <= r_sign1 ? (r_q - r_prod) : (r_q + r_prod);
         r_day2  <= r_day1;
         r_path2 <= r_path1;

         r_path_valid <= r_v2;
         r_path_last  <= r_v2 && (r_day2 == c_LAST_DAY) && (r_path2 == c_LAST_PATH);
         // r_path doubles as S_(d-1): it only moves on a real day so bubbles keep it.
         if (r_v2 && !i_abort) begin
            r_path     <= fp12_mult(r_sum, (r_day2 == '0) ? r_s0 : r_path);
            r_path_day <= r_day2;
            r_path_idx <= r_path2;
         end

         if (i_abort) begin
            r_state      <= S_IDLE;
            r_eps_ready  <= 1'b0;
            r_busy       <= 1'b0;
            r_day_cnt    <= '0;
            r_path_cnt   <= '0;
            r_v1         <= 1'b0;
            r_v2         <= 1'b0;
            r_path_valid <= 1'b0;
            r_path_last  <= 1'b0;
         end else begin
            case (r_state)
               S_IDLE: begin
                  if (i_start) begin
                     r_w         <= i_w;
                     r_q         <= i_q;
                     r_s0        <= i_s0;
                     r_day_cnt   <= '0;
                     r_path_cnt  <= '0;
                     r_state     <= S_RUN;
                     r_eps_ready <= 1'b1;
                     r_busy      <= 1'b1;
                  end
               end
               S_RUN: begin
                  if (w_accept) begin
                     if (r_day_cnt == c_LAST_DAY) begin
                        r_day_cnt  <= '0;
                        r_path_cnt <= r_path_cnt + PATH_W'(1);
                     end else begin
                        r_day_cnt  <= r_day_cnt + DAY_W'(1);
                     end
                     if (w_last_accept) begin
                        r_state     <= S_DRAIN;
                        r_eps_ready <= 1'b0;
                     end
                  end
               end
               S_DRAIN: begin
                  // The S3 result of the final day is already leaving this cycle.
                  if (!r_v1 && !r_v2) begin
                     r_state <= S_IDLE;
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
                  end
               end
               default: begin
                  r_state     <= S_IDLE;
                  r_eps_ready <= 1'b0;
                  r_busy      <= 1'b0;
               end
            endcase
         end
      end
   end

   assign o_eps_ready  = r_eps_ready;
   assign o_busy       = r_busy;
   assign o_done       = r_done;
   assign o_path_valid = r_path_valid;
   assign o_path       = r_path;
   assign o_path_day   = r_path_day;
   assign o_path_idx   = r_path_idx;
   assign o_path_last  = r_path_last;

endmodule

`default_nettype wire
